// File: rtl/uart_receiver_if.sv
// Byte-level side of the UART receiver: serial line in, recovered byte and status out.
interface uart_receiver_if;
  logic       rx;
  logic [7:0] out;
  logic       done;
  logic       busy;
  logic       err;

  modport master (output rx, input out, done, busy, err);
  modport slave  (input rx, output out, done, busy, err);
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: oversampled start/data/stop recovery using a clock-enable tick,
// one-cycle done strobe per good byte, sticky framing error.
module uart_receiver #(
  parameter int unsigned CLOCK_RATE         = 100000000,
  parameter int unsigned BAUD_RATE          = 9600,
  parameter int unsigned RX_OVERSAMPLE_RATE = 16
) (
  input  logic            clk,
  input  logic            reset,
  uart_receiver_if.slave  bus
);

  localparam int unsigned TICK_DIV = CLOCK_RATE / (BAUD_RATE * RX_OVERSAMPLE_RATE);
  localparam int unsigned HALF     = RX_OVERSAMPLE_RATE / 2;
  localparam int unsigned TICK_W   = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
  localparam int unsigned CNT_W    = $clog2(RX_OVERSAMPLE_RATE);

  if (TICK_DIV < 2) begin : gTickDivCheck
    $error("uart_receiver: TICK_DIV must be at least 2");
  end
  if ((RX_OVERSAMPLE_RATE < 4) || (RX_OVERSAMPLE_RATE % 2 != 0)) begin : gOversampleCheck
    $error("uart_receiver: RX_OVERSAMPLE_RATE must be even and at least 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state, stateNext;
  logic [TICK_W-1:0] tickCnt;
  logic              tick;
  logic              rxMeta, rxs;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [2:0]        idx, idxNext;
  logic [7:0]        sh, shNext;
  logic [7:0]        outReg, outNext;
  logic              doneReg, doneNext;
  logic              busyReg, busyNext;
  logic              errReg, errNext;
  logic              armed, armedNext;

  assign tick     = (tickCnt == TICK_W'(TICK_DIV - 1));
  assign bus.out  = outReg;
  assign bus.done = doneReg;
  assign bus.busy = busyReg;
  assign bus.err  = errReg;

  // State, datapath, synchronizer and tick divider registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tickCnt <= '0;
      rxMeta  <= 1'b1;
      rxs     <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      outReg  <= 8'h00;
      doneReg <= 1'b0;
      busyReg <= 1'b0;
      errReg  <= 1'b0;
      armed   <= 1'b0;
    end else begin
      tickCnt <= tick ? '0 : tickCnt + TICK_W'(1);
      rxMeta  <= bus.rx;
      rxs     <= rxMeta;
      state   <= stateNext;
      cnt     <= cntNext;
      idx     <= idxNext;
      sh      <= shNext;
      outReg  <= outNext;
      doneReg <= doneNext;
      busyReg <= busyNext;
      errReg  <= errNext;
      armed   <= armedNext;
    end
  end

  // Frame sequencing; everything advances only on oversample ticks
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    idxNext   = idx;
    shNext    = sh;
    outNext   = outReg;
    doneNext  = 1'b0;
    errNext   = errReg;
    armedNext = armed;

    if (tick) begin
      unique case (state)
        IDLE: begin
          // Requiring a high sample first keeps a held-low line from retriggering
          if (rxs) begin
            armedNext = 1'b1;
          end else if (armed) begin
            stateNext = START;
            cntNext   = '0;
            armedNext = 1'b0;
          end
        end
        START: begin
          if (cnt == CNT_W'(HALF - 1)) begin
            if (!rxs) begin
              stateNext = DATA;
              cntNext   = '0;
              idxNext   = '0;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_W'(RX_OVERSAMPLE_RATE - 1)) begin
            shNext  = {rxs, sh[7:1]};
            cntNext = '0;
            if (idx == 3'd7) begin
              stateNext = STOP;
            end else begin
              idxNext = idx + 3'd1;
            end
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_W'(RX_OVERSAMPLE_RATE - 1)) begin
            if (rxs) begin
              outNext  = sh;
              doneNext = 1'b1;
              errNext  = 1'b0;
            end else begin
              errNext = 1'b1;
            end
            stateNext = IDLE;
            cntNext   = '0;
          end else begin
            cntNext = cnt + CNT_W'(1);
          end
        end
        default: stateNext = IDLE;
      endcase
    end

    busyNext = (stateNext != IDLE);
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: scenario tasks drive serial frames and
// compare recovered bytes from a monitor log against an expected-byte queue.
module tb_uart_receiver;

  localparam int unsigned CLK_RATE = 1536000;
  localparam int unsigned BAUD     = 9600;
  localparam int unsigned OVS      = 16;
  localparam int          BIT_CLK  = int'(CLK_RATE / BAUD);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_receiver_if bus ();

  uart_receiver #(
    .CLOCK_RATE(CLK_RATE),
    .BAUD_RATE(BAUD),
    .RX_OVERSAMPLE_RATE(OVS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;
  int rdPtr = 0;
  logic [7:0] expQ[$];

  // Monitor: logs every done pulse and flags any pulse longer than one cycle
  int         cyc = 0;
  int         doneCount = 0;
  int         doneLong = 0;
  logic       prevDone = 1'b0;
  logic [7:0] gotLog [0:63];
  int         gotCycle [0:63];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.done === 1'b1) begin
      if (doneCount < 64) begin
        gotLog[doneCount]   <= bus.out;
        gotCycle[doneCount] <= cyc;
      end
      doneCount <= doneCount + 1;
      if (prevDone === 1'b1) doneLong <= doneLong + 1;
    end
    prevDone <= bus.done;
  end

  task automatic driveBit(input logic v, input int period);
    bus.rx = v;
    repeat (period) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopBit, input int period);
    if (stopBit) expQ.push_back(d);
    driveBit(1'b0, period);
    for (int i = 0; i < 8; i++) driveBit(d[i], period);
    driveBit(stopBit, period);
  endtask

  task automatic test_reset;
    bus.rx = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (bus.out !== 8'h00) begin bad++; $display("FAIL reset_out: got %h want 00", bus.out); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
    reset = 1'b0;
    repeat (2000) @(negedge clk);
    total++; if (doneCount !== 0) begin bad++; $display("FAIL idle_done: got %0d pulses want 0", doneCount); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_frame;
    int startCyc;
    logic [7:0] exp;
    startCyc = cyc;
    sendFrame(8'hA5, 1'b1, BIT_CLK);
    for (int k = 0; k < 200 && doneCount < rdPtr + 1; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++; if (doneCount !== rdPtr + 1) begin bad++; $display("FAIL a5_count: got %0d want %0d", doneCount, rdPtr + 1); end
    exp = expQ.pop_front();
    total++; if (gotLog[rdPtr] !== exp) begin bad++; $display("FAIL a5_out: got %h want %h", gotLog[rdPtr], exp); end
    total++; if (gotCycle[rdPtr] - startCyc > 1540) begin bad++; $display("FAIL a5_latency: got %0d want <=1540", gotCycle[rdPtr] - startCyc); end
    rdPtr++;
    total++; if (bus.out !== 8'hA5) begin bad++; $display("FAIL a5_hold: got %h want a5", bus.out); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL a5_err: got %b want 0", bus.err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL a5_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_glitch;
    int base;
    int busyCycles;
    base = doneCount;
    busyCycles = 0;
    bus.rx = 1'b0;
    repeat (40) begin @(negedge clk); if (bus.busy === 1'b1) busyCycles++; end
    bus.rx = 1'b1;
    repeat (160) begin @(negedge clk); if (bus.busy === 1'b1) busyCycles++; end
    total++; if (busyCycles < 75 || busyCycles > 85) begin bad++; $display("FAIL glitch_busy_len: got %0d want 75..85", busyCycles); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end: got %b want 0", bus.busy); end
    total++; if (doneCount !== base) begin bad++; $display("FAIL glitch_done: got %0d want %0d", doneCount, base); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL glitch_err: got %b want 0", bus.err); end
    total++; if (bus.out !== 8'hA5) begin bad++; $display("FAIL glitch_out: got %h want a5", bus.out); end
  endtask

  task automatic test_framing_error;
    int base;
    int lowBusy;
    logic [7:0] exp;
    base = doneCount;
    lowBusy = 0;
    sendFrame(8'h3C, 1'b0, BIT_CLK);
    repeat (500) begin @(negedge clk); if (bus.busy === 1'b1) lowBusy++; end
    total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ferr_err: got %b want 1", bus.err); end
    total++; if (doneCount !== base) begin bad++; $display("FAIL ferr_done: got %0d want %0d", doneCount, base); end
    total++; if (bus.out !== 8'hA5) begin bad++; $display("FAIL ferr_out: got %h want a5", bus.out); end
    total++; if (lowBusy !== 0) begin bad++; $display("FAIL ferr_break_busy: got %0d busy cycles want 0", lowBusy); end
    driveBit(1'b1, 2 * BIT_CLK);
    sendFrame(8'hFF, 1'b1, BIT_CLK);
    for (int k = 0; k < 200 && doneCount < rdPtr + 1; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++; if (doneCount !== rdPtr + 1) begin bad++; $display("FAIL ff_count: got %0d want %0d", doneCount, rdPtr + 1); end
    exp = expQ.pop_front();
    total++; if (gotLog[rdPtr] !== exp) begin bad++; $display("FAIL ff_out: got %h want %h", gotLog[rdPtr], exp); end
    rdPtr++;
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL ff_err: got %b want 0", bus.err); end
  endtask

  task automatic test_back_to_back;
    int periods [0:2];
    int base;
    logic [7:0] exp;
    periods = '{160, 155, 165};
    for (int p = 0; p < 3; p++) begin
      base = doneCount;
      sendFrame(8'h55, 1'b1, periods[p]);
      sendFrame(8'hAA, 1'b1, periods[p]);
      bus.rx = 1'b1;
      for (int k = 0; k < 300 && doneCount < base + 2; k++) @(negedge clk);
      repeat (200) @(negedge clk);
      total++; if (doneCount !== base + 2) begin bad++; $display("FAIL b2b_count_p%0d: got %0d want %0d", periods[p], doneCount - base, 2); end
      for (int j = 0; j < 2; j++) begin
        exp = expQ.pop_front();
        total++; if (gotLog[rdPtr] !== exp) begin bad++; $display("FAIL b2b_out_p%0d_%0d: got %h want %h", periods[p], j, gotLog[rdPtr], exp); end
        rdPtr++;
      end
      total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL b2b_err_p%0d: got %b want 0", periods[p], bus.err); end
      repeat (2 * BIT_CLK) @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe;
    int base;
    logic [7:0] exp;
    base = doneCount;
    driveBit(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) driveBit(1'b1, BIT_CLK);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", bus.busy); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_busy_after: got %b want 0", bus.busy); end
    reset = 1'b0;
    bus.rx = 1'b1;
    repeat (400) @(negedge clk);
    total++; if (doneCount !== base) begin bad++; $display("FAIL mid_done: got %0d want %0d", doneCount, base); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mid_err: got %b want 0", bus.err); end
    total++; if (bus.out !== 8'h00) begin bad++; $display("FAIL mid_out: got %h want 00", bus.out); end
    sendFrame(8'h81, 1'b1, BIT_CLK);
    for (int k = 0; k < 200 && doneCount < rdPtr + 1; k++) @(negedge clk);
    repeat (5) @(negedge clk);
    total++; if (doneCount !== rdPtr + 1) begin bad++; $display("FAIL r81_count: got %0d want %0d", doneCount, rdPtr + 1); end
    exp = expQ.pop_front();
    total++; if (gotLog[rdPtr] !== exp) begin bad++; $display("FAIL r81_out: got %h want %h", gotLog[rdPtr], exp); end
    rdPtr++;
  endtask

  initial begin
    bus.rx = 1'b1;
    test_reset();
    test_frame();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_midframe();
    total++; if (doneLong !== 0) begin bad++; $display("FAIL done_width: got %0d long pulses want 0", doneLong); end
    total++; if (expQ.size() !== 0) begin bad++; $display("FAIL scoreboard_left: got %0d pending want 0", expQ.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
